// File: rtl/pe_ns_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_ns_pkg
// Description : Shared constants and clear-FSM state encoding for the banked
//               namespace store.
// Revision    : 1.0
// ============================================================================
package pe_ns_pkg;

    localparam int c_num_ns_default     = 4;
    localparam int c_addr_len_default   = 6;
    localparam int c_data_len_default   = 32;
    localparam int c_inst_len_default   = 32;
    localparam int c_inst_depth_default = 8;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    // Selector width never collapses to zero bits, even with a single namespace.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_ns_bank.sv
`default_nettype none
// ============================================================================
// Module      : pe_ns_bank
// Description : One namespace RAM with a write port and a registered,
//               write-first read port.
// Revision    : 1.0
// ============================================================================
module pe_ns_bank #(
    parameter int ADDR_LEN = 6,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_wr_en,
    input  logic [ADDR_LEN-1:0] i_wr_addr,
    input  logic [DATA_LEN-1:0] i_wr_data,
    input  logic [ADDR_LEN-1:0] i_rd_addr,
    output logic [DATA_LEN-1:0] o_rd_data
);

    localparam int c_depth = 2 ** ADDR_LEN;

    logic [DATA_LEN-1:0] r_mem [c_depth];
    logic [DATA_LEN-1:0] r_rd_data;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_data <= '0;
        end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= i_wr_data;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pe_namespace_banked.sv
`default_nettype none
// ============================================================================
// Module      : pe_namespace_banked
// Description : Instruction FWFT FIFO plus NUM_NS independent namespace banks
//               with a sequential per-namespace clear engine.
// Revision    : 1.0
// ============================================================================
module pe_namespace_banked
    import pe_ns_pkg::*;
#(
    parameter int NUM_NS     = c_num_ns_default,
    parameter int ADDR_LEN   = c_addr_len_default,
    parameter int DATA_LEN   = c_data_len_default,
    parameter int INST_LEN   = c_inst_len_default,
    parameter int INST_DEPTH = c_inst_depth_default,
    localparam int CLR_SEL_W = sel_width(NUM_NS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inst_wrt,
    input  logic [INST_LEN-1:0]          inst_in,
    output logic                         inst_fifo_full,
    output logic [$clog2(INST_DEPTH):0]  inst_count,
    input  logic                         inst_stall,
    output logic [INST_LEN-1:0]          inst_out,
    output logic                         inst_valid,
    input  logic [NUM_NS-1:0]            ns_wrt,
    input  logic [NUM_NS*ADDR_LEN-1:0]   ns_wrt_addr,
    input  logic [NUM_NS*ADDR_LEN-1:0]   ns_rd_addr,
    input  logic [NUM_NS*DATA_LEN-1:0]   ns_in,
    output logic [NUM_NS*DATA_LEN-1:0]   ns_out,
    input  logic                         clr_start,
    input  logic [CLR_SEL_W-1:0]         clr_sel,
    output logic                         clr_busy
);

    localparam int c_ptr_w = $clog2(INST_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [INST_LEN-1:0] r_fifo [INST_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_full;
    logic                w_valid;
    logic                w_push;
    logic                w_pop;

    assign w_full  = (r_count == c_cnt_w'(INST_DEPTH));
    assign w_valid = (r_count != '0);
    // Fullness is judged before any same-cycle pop, so a push while full is lost.
    assign w_push  = inst_wrt && !w_full;
    assign w_pop   = w_valid && !inst_stall;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= inst_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign inst_fifo_full = w_full;
    assign inst_count     = r_count;
    assign inst_valid     = w_valid;
    assign inst_out       = w_valid ? r_fifo[r_rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    clr_state_e           r_state;
    clr_state_e           w_state_nxt;
    logic [ADDR_LEN-1:0]  r_clr_addr;
    logic [CLR_SEL_W-1:0] r_clr_ns;
    logic                 w_sel_ok;
    logic                 w_busy;

    assign w_sel_ok = (int'(clr_sel) < NUM_NS);
    assign w_busy   = (r_state == CLR_CLEAR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= CLR_IDLE;
            r_clr_addr <= '0;
            r_clr_ns   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == CLR_IDLE) && (w_state_nxt == CLR_CLEAR)) begin
                r_clr_ns   <= clr_sel;
                r_clr_addr <= '0;
            end else if (r_state == CLR_CLEAR) begin
                r_clr_addr <= r_clr_addr + ADDR_LEN'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLR_IDLE: begin
                if (clr_start && w_sel_ok) begin
                    w_state_nxt = CLR_CLEAR;
                end
            end
            CLR_CLEAR: begin
                if (r_clr_addr == {ADDR_LEN{1'b1}}) begin
                    w_state_nxt = CLR_IDLE;
                end
            end
            default: w_state_nxt = CLR_IDLE;
        endcase
    end

    assign clr_busy = w_busy;

    // ------------------------------------------------------------------
    // Namespace banks; the clear engine owns the write port of its target
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_NS; g++) begin : g_bank
        logic                w_clr_hit;
        logic                w_wr_en;
        logic [ADDR_LEN-1:0] w_wr_addr;
        logic [DATA_LEN-1:0] w_wr_data;

        assign w_clr_hit = w_busy && (r_clr_ns == CLR_SEL_W'(g));
        assign w_wr_en   = w_clr_hit | ns_wrt[g];
        assign w_wr_addr = w_clr_hit ? r_clr_addr : ns_wrt_addr[g*ADDR_LEN +: ADDR_LEN];
        assign w_wr_data = w_clr_hit ? '0 : ns_in[g*DATA_LEN +: DATA_LEN];

        pe_ns_bank #(
            .ADDR_LEN (ADDR_LEN),
            .DATA_LEN (DATA_LEN)
        ) u_bank (
            .clk       (clk),
            .reset     (reset),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (w_wr_addr),
            .i_wr_data (w_wr_data),
            .i_rd_addr (ns_rd_addr[g*ADDR_LEN +: ADDR_LEN]),
            .o_rd_data (ns_out[g*DATA_LEN +: DATA_LEN])
        );
    end

endmodule
`default_nettype wire
